monitor_cmd_ctrl: RTL and testbench



---
 rtl/monitor_pkg.sv | 46 ++++
 rtl/monitor_cmd_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_monitor_cmd_ctrl.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/monitor_pkg.sv
// ---------------------------------------------------------------------------
// monitor_pkg
//   Definitions shared by the monitor command path:
//     - bit positions and widths of the fields in a 40-bit decoded command
//     - the command-execution state encoding
//     - the read data returned when a bus transfer is aborted
//     - build_resp(): packs a read response message
// ---------------------------------------------------------------------------
package monitor_pkg;

  localparam int CMD_W       = 40;

  // Command word layout: {rd_flag, group, addr, data}
  localparam int RD_FLAG_BIT = 39;
  localparam int GROUP_MSB   = 38;
  localparam int GROUP_LSB   = 32;
  localparam int GROUP_W     = GROUP_MSB - GROUP_LSB + 1;
  localparam int ADDR_MSB    = 31;
  localparam int ADDR_LSB    = 16;
  localparam int ADDR_W      = ADDR_MSB - ADDR_LSB + 1;
  localparam int DATA_MSB    = 15;
  localparam int DATA_LSB    = 0;
  localparam int DATA_W      = DATA_MSB - DATA_LSB + 1;

  // Read data reported when a read is aborted by the bus timeout
  localparam logic [DATA_W-1:0] ABORT_DATA = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LATCH = 3'd2,
    ST_REQ   = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Response message: the upper 24 bits echo the command, the low 16 carry data
  function automatic logic [CMD_W-1:0] build_resp(
    input logic              rd_flag,
    input logic [GROUP_W-1:0] group,
    input logic [ADDR_W-1:0]  addr,
    input logic [DATA_W-1:0]  data
  );
    return {rd_flag, group, addr, data};
  endfunction

endpackage

// File: rtl/monitor_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// monitor_cmd_ctrl
//   Executes decoded monitor commands one at a time. A command is popped from
//   the command FIFO, latched, and performed as one read or write on the
//   internal register bus. Reads push a 40-bit response into the read message
//   FIFO; writes produce no response.
//
//   Build option:
//     MON_BUS_TIMEOUT_EN  when defined, a 16-bit counter aborts a bus request
//                         that has waited TIMEOUT_CYCLES cycles without ack.
//                         When undefined, REQ waits for bus_ack forever and
//                         timeout is tied low.
//
//   Parameters:
//     TIMEOUT_CYCLES  REQ cycles without bus_ack before abort (2..65535)
//
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     cmd             command word, valid the cycle after cmd_read_en
//     cmd_ready       command queued and room in the read message FIFO
//     cmd_read_en     one-cycle pop strobe to the command FIFO
//     read_msg        response message
//     read_msg_ready  one-cycle write strobe to the read message FIFO
//     bus_req         bus request, held until ack or abort
//     bus_write       1 = write, 0 = read
//     bus_group       register group select
//     bus_addr        register address
//     bus_wdata       write data
//     bus_rdata       read data, sampled in the bus_ack cycle
//     bus_ack         transfer completes in this cycle
//     busy            high whenever the controller is not idle
//     timeout         one-cycle pulse after a transfer is aborted
// ---------------------------------------------------------------------------
module monitor_cmd_ctrl
  import monitor_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CMD_W-1:0]   cmd,
  input  logic               cmd_ready,
  output logic               cmd_read_en,
  output logic [CMD_W-1:0]   read_msg,
  output logic               read_msg_ready,
  output logic               bus_req,
  output logic               bus_write,
  output logic [GROUP_W-1:0] bus_group,
  output logic [ADDR_W-1:0]  bus_addr,
  output logic [DATA_W-1:0]  bus_wdata,
  input  logic [DATA_W-1:0]  bus_rdata,
  input  logic               bus_ack,
  output logic               busy,
  output logic               timeout
);

  state_t state_reg;
  state_t state_next;

  logic               rd_flag_reg;
  logic               bus_write_reg;
  logic [GROUP_W-1:0] bus_group_reg;
  logic [ADDR_W-1:0]  bus_addr_reg;
  logic [DATA_W-1:0]  bus_wdata_reg;
  logic [CMD_W-1:0]   read_msg_reg;
  logic               busy_reg;

  // High in the REQ cycle in which the wait budget runs out without an ack
  logic               abort_hit;

  // -------------------------------------------------------------------------
  // Optional bus timeout
  // -------------------------------------------------------------------------
`ifdef MON_BUS_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_reg;
  logic        timeout_reg;

  // Held at zero outside REQ, so every REQ visit starts counting from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg != ST_REQ) begin
      tmo_cnt_reg <= '0;
    end else if (!bus_ack) begin
      tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
    end
  end

  // An ack arriving in the final cycle takes priority over the abort
  assign abort_hit = (state_reg == ST_REQ) && !bus_ack && (tmo_cnt_reg == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= abort_hit;
    end
  end

  assign timeout = timeout_reg;
`else
  assign abort_hit = 1'b0;
  assign timeout   = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. cmd_ready matters only in IDLE, bus_ack only in REQ.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_ready) begin
          state_next = ST_POP;
        end
      end
      ST_POP: begin
        state_next = ST_LATCH;
      end
      ST_LATCH: begin
        state_next = ST_REQ;
      end
      ST_REQ: begin
        if (bus_ack || abort_hit) begin
          state_next = rd_flag_reg ? ST_RESP : ST_IDLE;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registered datapath and Moore outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_flag_reg   <= 1'b0;
      bus_write_reg <= 1'b0;
      bus_group_reg <= '0;
      bus_addr_reg  <= '0;
      bus_wdata_reg <= '0;
      read_msg_reg  <= '0;
      busy_reg      <= 1'b0;
    end else begin
      // busy tracks the state the FSM is entering, so it lines up with it
      busy_reg <= (state_next != ST_IDLE);

      // The FIFO presents the popped word during LATCH
      if (state_reg == ST_LATCH) begin
        rd_flag_reg   <= cmd[RD_FLAG_BIT];
        bus_write_reg <= ~cmd[RD_FLAG_BIT];
        bus_group_reg <= cmd[GROUP_MSB:GROUP_LSB];
        bus_addr_reg  <= cmd[ADDR_MSB:ADDR_LSB];
        bus_wdata_reg <= cmd[DATA_MSB:DATA_LSB];
      end

      // A read leaving REQ always produces a response, real or abort data
      if ((state_reg == ST_REQ) && rd_flag_reg && (bus_ack || abort_hit)) begin
        read_msg_reg <= build_resp(rd_flag_reg, bus_group_reg, bus_addr_reg,
                                   bus_ack ? bus_rdata : ABORT_DATA);
      end
    end
  end

  // Strobes decoded from the state register alone; reset clears them at once
  assign cmd_read_en    = (state_reg == ST_POP);
  assign read_msg_ready = (state_reg == ST_RESP);
  assign bus_req        = (state_reg == ST_REQ);

  assign bus_write = bus_write_reg;
  assign bus_group = bus_group_reg;
  assign bus_addr  = bus_addr_reg;
  assign bus_wdata = bus_wdata_reg;
  assign read_msg  = read_msg_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_monitor_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_monitor_cmd_ctrl
//   Directed bench for monitor_cmd_ctrl. A small command-FIFO model and a
//   bus responder are advanced one clock at a time by tick(); each test task
//   drives stimulus and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_monitor_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] cmd;
  logic        cmd_ready;
  logic        cmd_read_en;
  logic [39:0] read_msg;
  logic        read_msg_ready;
  logic        bus_req;
  logic        bus_write;
  logic [6:0]  bus_group;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_ack;
  logic        busy;
  logic        timeout;

  always #5 clk = ~clk;

  monitor_cmd_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd            (cmd),
    .cmd_ready      (cmd_ready),
    .cmd_read_en    (cmd_read_en),
    .read_msg       (read_msg),
    .read_msg_ready (read_msg_ready),
    .bus_req        (bus_req),
    .bus_write      (bus_write),
    .bus_group      (bus_group),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .bus_ack        (bus_ack),
    .busy           (busy),
    .timeout        (timeout)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [39:0] q[$];
  logic [39:0] resp_q[$];
  int          resp_cyc[$];
  int          n_pop;
  int          n_tmo;
  int          tmo_cyc;
  int          req_cnt;
  int          max_req;
  int          ack_delay;
  logic [15:0] rdata_val;
  bit          rdata_xor;
  bit          spurious_ack;

  // Advance one clock; all inputs change 1 ns after the rising edge
  task automatic tick();
    logic pop;
    pop = cmd_read_en;
    @(posedge clk);
    #1;
    cyc++;
    if (pop && q.size() > 0) cmd = q.pop_front();
    cmd_ready = (q.size() > 0);
    if (cmd_read_en) n_pop++;
    if (read_msg_ready) begin
      resp_q.push_back(read_msg);
      resp_cyc.push_back(cyc);
    end
    if (timeout) begin
      n_tmo++;
      tmo_cyc = cyc;
    end
    if (bus_req) begin
      req_cnt++;
      if (req_cnt > max_req) max_req = req_cnt;
      bus_ack   = (ack_delay >= 0) && (req_cnt == ack_delay + 1);
      bus_rdata = rdata_xor ? (bus_addr ^ 16'h5A5A) : rdata_val;
    end else begin
      req_cnt   = 0;
      bus_ack   = spurious_ack;
      bus_rdata = 16'h0000;
    end
  endtask

  task automatic clear_mon();
    resp_q.delete();
    resp_cyc.delete();
    n_pop   = 0;
    n_tmo   = 0;
    tmo_cyc = -1;
    max_req = 0;
  endtask

  task automatic push_cmd(input logic [39:0] c);
    q.push_back(c);
    cmd_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({cmd_read_en, read_msg_ready, bus_req, bus_write, busy, timeout} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
               {cmd_read_en, read_msg_ready, bus_req, bus_write, busy, timeout});
    end
    checks++;
    if ({bus_group, bus_addr, bus_wdata} !== 39'h0) begin
      errors++;
      $display("FAIL reset_bus got %h want 0", {bus_group, bus_addr, bus_wdata});
    end
    checks++;
    if (read_msg !== 40'h0) begin
      errors++;
      $display("FAIL reset_msg got %h want 0", read_msg);
    end
    rst = 1'b0;
    tick();
    $display("reset: released");
  endtask

  task automatic test_write();
    clear_mon();
    ack_delay = 0;
    rdata_xor = 1'b0;
    push_cmd(40'h05_0123_BEEF);
    tick();
    checks++;
    if ({cmd_read_en, busy} !== 2'b11) begin
      errors++;
      $display("FAIL write_pop got en/busy %b want 11", {cmd_read_en, busy});
    end
    tick();
    checks++;
    if (cmd_read_en !== 1'b0) begin
      errors++;
      $display("FAIL write_pop_width got %b want 0", cmd_read_en);
    end
    tick();
    checks++;
    if (bus_req !== 1'b1) begin
      errors++;
      $display("FAIL write_req got %b want 1", bus_req);
    end
    checks++;
    if ({bus_write, bus_group, bus_addr, bus_wdata} !== {1'b1, 7'h05, 16'h0123, 16'hBEEF}) begin
      errors++;
      $display("FAIL write_fields got %b/%h/%h/%h want 1/05/0123/beef",
               bus_write, bus_group, bus_addr, bus_wdata);
    end
    tick();
    checks++;
    if ({busy, bus_req} !== 2'b00) begin
      errors++;
      $display("FAIL write_idle got busy/req %b want 00", {busy, bus_req});
    end
    repeat (3) tick();
    checks++;
    if (resp_q.size() != 0 || n_pop != 1) begin
      errors++;
      $display("FAIL write_noresp got resp %0d pops %0d want 0 1", resp_q.size(), n_pop);
    end
    $display("write: cmd 05_0123_beef done at cycle %0d", cyc);
  endtask

  task automatic test_read();
    int start;
    clear_mon();
    ack_delay = 3;
    rdata_val = 16'h1234;
    start = cyc;
    push_cmd(40'h8A_0040_0000);
    repeat (12) tick();
    checks++;
    if (resp_q.size() != 1) begin
      errors++;
      $display("FAIL read_count got %0d want 1", resp_q.size());
    end else begin
      checks++;
      if (resp_q[0] !== 40'h8A_0040_1234) begin
        errors++;
        $display("FAIL read_msg got %h want 8a00401234", resp_q[0]);
      end
      checks++;
      if (resp_cyc[0] - start != 7) begin
        errors++;
        $display("FAIL read_latency got %0d want 7", resp_cyc[0] - start);
      end
    end
    checks++;
    if (max_req != 4 || n_tmo != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL read_req got req %0d tmo %0d busy %b want 4 0 0", max_req, n_tmo, busy);
    end
    $display("read: cmd 8a_0040_0000 responses %0d", resp_q.size());
  endtask

  task automatic test_back_to_back();
    int start;
    logic [39:0] exp_msg [3];
    exp_msg[0] = 40'h81_0001_5A5B;
    exp_msg[1] = 40'h82_0002_5A58;
    exp_msg[2] = 40'h83_0003_5A59;
    clear_mon();
    ack_delay = 0;
    rdata_xor = 1'b1;
    start = cyc;
    push_cmd(40'h81_0001_0000);
    push_cmd(40'h82_0002_0000);
    push_cmd(40'h83_0003_0000);
    repeat (20) tick();
    rdata_xor = 1'b0;
    checks++;
    if (n_pop != 3) begin
      errors++;
      $display("FAIL b2b_pops got %0d want 3", n_pop);
    end
    checks++;
    if (resp_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_count got %0d want 3", resp_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (resp_q[i] !== exp_msg[i]) begin
          errors++;
          $display("FAIL b2b_msg%0d got %h want %h", i, resp_q[i], exp_msg[i]);
        end
      end
      checks++;
      if (resp_cyc[0] - start != 4 || resp_cyc[1] - resp_cyc[0] != 5 ||
          resp_cyc[2] - resp_cyc[1] != 5) begin
        errors++;
        $display("FAIL b2b_spacing got %0d/%0d/%0d want 4/5/5", resp_cyc[0] - start,
                 resp_cyc[1] - resp_cyc[0], resp_cyc[2] - resp_cyc[1]);
      end
    end
    $display("back_to_back: pops %0d responses %0d", n_pop, resp_q.size());
  endtask

  task automatic test_timeout();
    int start;
`ifdef MON_BUS_TIMEOUT_EN
    clear_mon();
    ack_delay = -1;
    start = cyc;
    push_cmd(40'h8C_0100_0000);
    repeat (16) tick();
    checks++;
    if (n_tmo != 1 || max_req != 8) begin
      errors++;
      $display("FAIL tmo_abort got pulses %0d req %0d want 1 8", n_tmo, max_req);
    end
    checks++;
    if (tmo_cyc - start != 11) begin
      errors++;
      $display("FAIL tmo_when got %0d want 11", tmo_cyc - start);
    end
    checks++;
    if (resp_q.size() != 1) begin
      errors++;
      $display("FAIL tmo_count got %0d want 1", resp_q.size());
    end else begin
      checks++;
      if (resp_q[0] !== 40'h8C_0100_FFFF || resp_cyc[0] - start != 11) begin
        errors++;
        $display("FAIL tmo_msg got %h at %0d want 8c0100ffff at 11", resp_q[0], resp_cyc[0] - start);
      end
    end
    clear_mon();
    ack_delay = 7;
    rdata_val = 16'h4321;
    push_cmd(40'h8C_0100_0000);
    repeat (16) tick();
    checks++;
    if (n_tmo != 0 || max_req != 8) begin
      errors++;
      $display("FAIL tmo_ackwins got pulses %0d req %0d want 0 8", n_tmo, max_req);
    end
    checks++;
    if (resp_q.size() != 1) begin
      errors++;
      $display("FAIL tmo_ack_count got %0d want 1", resp_q.size());
    end else begin
      checks++;
      if (resp_q[0] !== 40'h8C_0100_4321) begin
        errors++;
        $display("FAIL tmo_ack_msg got %h want 8c01004321", resp_q[0]);
      end
    end
    $display("timeout: abort and last-cycle ack exercised");
`else
    clear_mon();
    ack_delay = -1;
    start = cyc;
    push_cmd(40'h8C_0100_0000);
    repeat (40) tick();
    checks++;
    if (bus_req !== 1'b1 || n_tmo != 0 || resp_q.size() != 0) begin
      errors++;
      $display("FAIL notmo_wait got req %b tmo %0d resp %0d want 1 0 0",
               bus_req, n_tmo, resp_q.size());
    end
    ack_delay = req_cnt;
    rdata_val = 16'h4321;
    repeat (4) tick();
    checks++;
    if (resp_q.size() != 1) begin
      errors++;
      $display("FAIL notmo_count got %0d want 1", resp_q.size());
    end else begin
      checks++;
      if (resp_q[0] !== 40'h8C_0100_4321) begin
        errors++;
        $display("FAIL notmo_msg got %h want 8c01004321", resp_q[0]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL notmo_idle got busy %b want 0", busy);
    end
    $display("timeout: disabled build waited %0d cycles from cycle %0d", max_req, start);
`endif
  endtask

  task automatic test_reset_mid_req();
    int n;
    clear_mon();
    ack_delay = -1;
    push_cmd(40'h91_0777_0000);
    n = 0;
    while (bus_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (bus_req !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_reach got bus_req %b want 1", bus_req);
    end
    tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus_req, busy, read_msg_ready, cmd_read_en, bus_write} !== 5'b0) begin
      errors++;
      $display("FAIL rstmid_async got %b want 00000",
               {bus_req, busy, read_msg_ready, cmd_read_en, bus_write});
    end
    checks++;
    if ({bus_group, bus_addr} !== 23'h0) begin
      errors++;
      $display("FAIL rstmid_fields got %h want 0", {bus_group, bus_addr});
    end
    tick();
    tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (resp_q.size() != 0 || n_tmo != 0) begin
      errors++;
      $display("FAIL rstmid_noresp got resp %0d tmo %0d want 0 0", resp_q.size(), n_tmo);
    end
    clear_mon();
    ack_delay = 0;
    push_cmd(40'h7F_FFFF_0001);
    repeat (3) tick();
    checks++;
    if ({bus_req, bus_write, bus_group, bus_addr, bus_wdata} !==
        {1'b1, 1'b1, 7'h7F, 16'hFFFF, 16'h0001}) begin
      errors++;
      $display("FAIL rstmid_next got %b/%b/%h/%h/%h want 1/1/7f/ffff/0001",
               bus_req, bus_write, bus_group, bus_addr, bus_wdata);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || n_pop != 1 || resp_q.size() != 0) begin
      errors++;
      $display("FAIL rstmid_done got busy %b pops %0d resp %0d want 0 1 0",
               busy, n_pop, resp_q.size());
    end
    $display("reset_mid_req: recovered at cycle %0d", cyc);
  endtask

  task automatic test_spurious_ack();
    clear_mon();
    spurious_ack = 1'b1;
    repeat (3) tick();
    checks++;
    if ({cmd_read_en, bus_req, busy, read_msg_ready, timeout} !== 5'b0) begin
      errors++;
      $display("FAIL spur_idle got %b want 00000",
               {cmd_read_en, bus_req, busy, read_msg_ready, timeout});
    end
    ack_delay = 0;
    push_cmd(40'h33_00AA_5555);
    tick();
    checks++;
    if ({cmd_read_en, busy} !== 2'b11) begin
      errors++;
      $display("FAIL spur_pop got en/busy %b want 11", {cmd_read_en, busy});
    end
    spurious_ack = 1'b0;
    tick();
    checks++;
    if ({bus_req, cmd_read_en, busy} !== 3'b001) begin
      errors++;
      $display("FAIL spur_latch got req/en/busy %b want 001", {bus_req, cmd_read_en, busy});
    end
    tick();
    checks++;
    if ({bus_req, bus_write, bus_group, bus_addr, bus_wdata} !==
        {1'b1, 1'b1, 7'h33, 16'h00AA, 16'h5555}) begin
      errors++;
      $display("FAIL spur_req got %b/%b/%h/%h/%h want 1/1/33/00aa/5555",
               bus_req, bus_write, bus_group, bus_addr, bus_wdata);
    end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || n_pop != 1 || resp_q.size() != 0) begin
      errors++;
      $display("FAIL spur_done got busy %b pops %0d resp %0d want 0 1 0",
               busy, n_pop, resp_q.size());
    end
    $display("spurious_ack: ignored in idle and pop");
  endtask

  initial begin
    rst          = 1'b1;
    cmd          = 40'h0;
    cmd_ready    = 1'b0;
    bus_ack      = 1'b0;
    bus_rdata    = 16'h0;
    ack_delay    = -1;
    rdata_val    = 16'h0;
    rdata_xor    = 1'b0;
    spurious_ack = 1'b0;
    req_cnt      = 0;
    clear_mon();

    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_timeout();
    test_reset_mid_req();
    test_spurious_ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d want finish earlier", cyc);
    $fatal(1, "watchdog");
  end

endmodule
